// File: rtl/column_frame_buffer.sv
// Double-buffered column RAM for the ray-cast stream with a 2-cycle per-pixel colour lookup.
// Optional macro COLUMN_SHADE_EN stores y_side per column and halves y-side wall pixels.
module column_frame_buffer #(
  parameter int         SCREEN_WIDTH  = 640,
  parameter int         SCREEN_HEIGHT = 600,
  parameter logic [7:0] CEIL_COLOR    = 8'h25,
  parameter logic [7:0] FLOOR_COLOR   = 8'h49
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       col_valid,
  input  logic [9:0] col_index,
  input  logic [9:0] col_height,
  input  logic [7:0] col_color,
  input  logic       col_y_side,
  input  logic       frame_start,
  input  logic       pix_valid,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic       pix_out_valid,
  output logic [7:0] pix_color,
  output logic       frame_swapped,
  output logic       col_drop
);

`ifdef COLUMN_SHADE_EN
  localparam int ENTRY_W = 19;
`else
  localparam int ENTRY_W = 18;
`endif
  localparam logic [10:0] WIDTH_11  = 11'(SCREEN_WIDTH);
  localparam logic [10:0] HEIGHT_11 = 11'(SCREEN_HEIGHT);
  localparam logic [9:0]  HEIGHT_10 = 10'(SCREEN_HEIGHT);
  localparam logic [9:0]  LAST_COL  = 10'(SCREEN_WIDTH - 1);

  logic [ENTRY_W-1:0] bank0 [SCREEN_WIDTH];
  logic [ENTRY_W-1:0] bank1 [SCREEN_WIDTH];

  logic               front_sel;
  logic               complete;
  logic               have_frame;
  logic               col_in_range;
  logic               pix_in_range;
  logic               wr_en;
  logic               swap_take;
  logic [9:0]         col_h_clamped;
  logic [9:0]         rd_addr;
  logic [ENTRY_W-1:0] wr_entry;

  logic               s1_valid;
  logic               s1_in_range;
  logic               s1_have;
  logic [9:0]         s1_y;
  logic [ENTRY_W-1:0] s1_entry;
  logic [9:0]         s1_h;
  logic [7:0]         s1_wall_color;
  logic [7:0]         s1_wall_shaded;
  logic [10:0]        slice_top;
  logic [10:0]        slice_bottom;
  logic [7:0]         pix_color_next;

  assign col_in_range  = {1'b0, col_index} < WIDTH_11;
  assign pix_in_range  = {1'b0, pix_x} < WIDTH_11;
  assign wr_en         = rst_n && col_valid && col_in_range;
  assign swap_take     = frame_start && complete;
  assign col_h_clamped = (col_height > HEIGHT_10) ? HEIGHT_10 : col_height;
  assign rd_addr       = pix_in_range ? pix_x : 10'd0;

`ifdef COLUMN_SHADE_EN
  assign wr_entry = {col_h_clamped, col_color, col_y_side};
`else
  logic unused_y_side;
  assign unused_y_side = col_y_side;
  assign wr_entry      = {col_h_clamped, col_color};
`endif

  // Writes always land in the bank that is not being displayed.
  always_ff @(posedge clk) begin
    if (wr_en && front_sel)  bank0[col_index] <= wr_entry;
    if (wr_en && !front_sel) bank1[col_index] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      front_sel     <= 1'b0;
      complete      <= 1'b0;
      have_frame    <= 1'b0;
      frame_swapped <= 1'b0;
      col_drop      <= 1'b0;
    end else begin
      frame_swapped <= swap_take;
      col_drop      <= col_valid && !col_in_range;
      if (swap_take) begin
        front_sel  <= !front_sel;
        complete   <= 1'b0;
        have_frame <= 1'b1;
      end else if (wr_en && (col_index == LAST_COL)) begin
        complete <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    s1_entry <= front_sel ? bank1[rd_addr] : bank0[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_in_range <= 1'b0;
      s1_have     <= 1'b0;
      s1_y        <= 10'd0;
    end else begin
      s1_valid    <= pix_valid;
      s1_in_range <= pix_in_range;
      s1_have     <= have_frame;
      s1_y        <= pix_y;
    end
  end

  assign s1_h          = s1_entry[ENTRY_W-1 -: 10];
  assign s1_wall_color = s1_entry[ENTRY_W-11 -: 8];
  // Heights are clamped on write, so the 11-bit subtraction never wraps.
  assign slice_top     = (HEIGHT_11 - {1'b0, s1_h}) >> 1;
  assign slice_bottom  = slice_top + {1'b0, s1_h};

`ifdef COLUMN_SHADE_EN
  assign s1_wall_shaded = s1_entry[0] ?
    {1'b0, s1_wall_color[7:6], 1'b0, s1_wall_color[4:3], 1'b0, s1_wall_color[1]} :
    s1_wall_color;
`else
  assign s1_wall_shaded = s1_wall_color;
`endif

  always_comb begin
    pix_color_next = 8'h00;
    if (s1_have && s1_in_range) begin
      if ({1'b0, s1_y} < slice_top)          pix_color_next = CEIL_COLOR;
      else if ({1'b0, s1_y} >= slice_bottom) pix_color_next = FLOOR_COLOR;
      else                                   pix_color_next = s1_wall_shaded;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_out_valid <= 1'b0;
      pix_color     <= 8'h00;
    end else begin
      pix_out_valid <= s1_valid;
      pix_color     <= pix_color_next;
    end
  end

endmodule

// File: tb/tb_column_frame_buffer.sv
// Self-checking bench for column_frame_buffer: directed scenarios plus randomized traffic
// compared against a frame-level reference model (honours COLUMN_SHADE_EN like the design).
module tb_column_frame_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       col_valid;
  logic [9:0] col_index;
  logic [9:0] col_height;
  logic [7:0] col_color;
  logic       col_y_side;
  logic       frame_start;
  logic       pix_valid;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       pix_out_valid;
  logic [7:0] pix_color;
  logic       frame_swapped;
  logic       col_drop;

  int checks = 0;
  int passed = 0;

  // Reference model: two banks of columns, which one is shown, and the frame flags.
  int         m_h  [2][640];
  logic [7:0] m_c  [2][640];
  bit         m_ys [2][640];
  bit         m_w  [2][640];
  int         m_front = 0;
  bit         m_complete = 0;
  bit         m_have = 0;
  bit         p1_v = 0, p1_k = 0;
  logic [7:0] p1_c = 8'h00;
  bit         exp_v = 0, exp_k = 0, exp_sw = 0, exp_dr = 0;
  logic [7:0] exp_c = 8'h00;

  column_frame_buffer dut (
    .clk(clk), .rst_n(rst_n), .col_valid(col_valid), .col_index(col_index),
    .col_height(col_height), .col_color(col_color), .col_y_side(col_y_side),
    .frame_start(frame_start), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_out_valid(pix_out_valid), .pix_color(pix_color),
    .frame_swapped(frame_swapped), .col_drop(col_drop)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_color(int x, int y);
    int h, top, bottom;
    logic [7:0] c;
    if (!m_have || x >= 640) return 8'h00;
    h = m_h[m_front][x];
    top = (600 - h) / 2;
    bottom = top + h;
    if (y < top) return 8'h25;
    if (y >= bottom) return 8'h49;
    c = m_c[m_front][x];
`ifdef COLUMN_SHADE_EN
    if (m_ys[m_front][x]) return {3'(c[7:5] / 2), 3'(c[4:2] / 2), 2'(c[1:0] / 2)};
`endif
    return c;
  endfunction

  // Advance one clock edge and update the model from the inputs present at that edge.
  task automatic tick();
    logic [7:0] nc;
    bit nk, sw;
    int b;
    @(posedge clk);
    if (!rst_n) begin
      m_front = 0; m_complete = 0; m_have = 0;
      p1_v = 0; exp_v = 0; exp_sw = 0; exp_dr = 0;
    end else begin
      nc = model_color(int'(pix_x), int'(pix_y));
      nk = !m_have || (pix_x >= 640) || m_w[m_front][pix_x];
      exp_v = p1_v; exp_c = p1_c; exp_k = p1_k;
      p1_v = pix_valid; p1_c = nc; p1_k = nk;
      sw = frame_start && m_complete;
      exp_sw = sw;
      exp_dr = col_valid && (col_index >= 640);
      if (col_valid && col_index < 640) begin
        b = 1 - m_front;
        m_h[b][col_index]  = (col_height > 600) ? 600 : int'(col_height);
        m_c[b][col_index]  = col_color;
        m_ys[b][col_index] = col_y_side;
        m_w[b][col_index]  = 1;
      end
      if (sw) begin
        m_front = 1 - m_front; m_complete = 0; m_have = 1;
      end else if (col_valid && col_index == 639) begin
        m_complete = 1;
      end
    end
    #1;
  endtask

  task automatic write_col(int idx, int h, logic [7:0] c, bit ys);
    col_valid = 1; col_index = 10'(idx); col_height = 10'(h); col_color = c; col_y_side = ys;
    tick();
    col_valid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) tick();
    checks++; if (pix_out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", pix_out_valid); else passed++;
    checks++; if (pix_color !== 8'h00) $display("[TB] FAIL reset_color: got %h expected 00", pix_color); else passed++;
    checks++; if (frame_swapped !== 1'b0 || col_drop !== 1'b0) $display("[TB] FAIL reset_pulses: got %b%b expected 00", frame_swapped, col_drop); else passed++;
    rst_n = 1;
    tick();
    pix_valid = 1; pix_x = 10'd5; pix_y = 10'd300;
    tick();
    pix_valid = 0;
    checks++; if (pix_out_valid !== 1'b0) $display("[TB] FAIL nf_early_valid: got %b expected 0", pix_out_valid); else passed++;
    tick();
    checks++; if (pix_out_valid !== 1'b1) $display("[TB] FAIL nf_valid: got %b expected 1", pix_out_valid); else passed++;
    checks++; if (pix_color !== 8'h00) $display("[TB] FAIL nf_color: got %h expected 00", pix_color); else passed++;
    frame_start = 1;
    tick();
    frame_start = 0;
    checks++; if (frame_swapped !== 1'b0) $display("[TB] FAIL nf_no_swap: got %b expected 0", frame_swapped); else passed++;
  endtask

  task automatic test_full_frame();
    int ys[4] = '{199, 200, 399, 400};
    logic [7:0] lit[4] = '{8'h25, 8'hE0, 8'hE0, 8'h49};
    for (int i = 0; i < 640; i++) write_col(i, 200, 8'hE0, 0);
    frame_start = 1;
    tick();
    frame_start = 0;
    checks++; if (frame_swapped !== 1'b1) $display("[TB] FAIL ff_swap: got %b expected 1", frame_swapped); else passed++;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin pix_valid = 1; pix_x = 10'd10; pix_y = 10'(ys[k]); end
      else pix_valid = 0;
      tick();
      if (k == 0) begin
        checks++; if (frame_swapped !== 1'b0) $display("[TB] FAIL ff_swap_len: got %b expected 0", frame_swapped); else passed++;
      end
      if (k >= 1) begin
        checks++; if (pix_out_valid !== 1'b1) $display("[TB] FAIL ff_valid%0d: got %b expected 1", k - 1, pix_out_valid); else passed++;
        checks++; if (pix_color !== lit[k-1] || pix_color !== exp_c) $display("[TB] FAIL ff_color%0d: got %h expected %h", k - 1, pix_color, lit[k-1]); else passed++;
      end
    end
  endtask

  task automatic test_edge_heights();
    int xs[4] = '{0, 0, 1, 1};
    int ys[4] = '{299, 300, 0, 599};
    logic [7:0] lit[4] = '{8'h25, 8'h49, 8'hC3, 8'hC3};
    write_col(0, 0, 8'hC3, 0);
    write_col(1, 1023, 8'hC3, 0);
    for (int i = 2; i < 640; i++) write_col(i, 600, 8'h03, 0);
    frame_start = 1;
    tick();
    frame_start = 0;
    checks++; if (frame_swapped !== 1'b1) $display("[TB] FAIL eh_swap: got %b expected 1", frame_swapped); else passed++;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin pix_valid = 1; pix_x = 10'(xs[k]); pix_y = 10'(ys[k]); end
      else pix_valid = 0;
      tick();
      if (k >= 1) begin
        checks++; if (pix_out_valid !== 1'b1 || pix_color !== lit[k-1] || pix_color !== exp_c) $display("[TB] FAIL eh_color%0d: got %b/%h expected 1/%h", k - 1, pix_out_valid, pix_color, lit[k-1]); else passed++;
      end
    end
  endtask

  task automatic test_coincident();
    logic [7:0] lit[4] = '{8'h03, 8'h03, 8'h1C, 8'h1C};
    for (int i = 0; i < 639; i++) write_col(i, 100, 8'h1C, 0);
    frame_start = 1;
    write_col(639, 100, 8'h1C, 0);
    frame_start = 0;
    checks++; if (frame_swapped !== 1'b0) $display("[TB] FAIL co_no_swap: got %b expected 0", frame_swapped); else passed++;
    for (int k = 0; k < 5; k++) begin
      frame_start = (k == 1);
      if (k < 4) begin pix_valid = 1; pix_x = 10'd20; pix_y = 10'd300; end
      else pix_valid = 0;
      tick();
      if (k == 1) begin
        checks++; if (frame_swapped !== 1'b1) $display("[TB] FAIL co_swap: got %b expected 1", frame_swapped); else passed++;
      end
      if (k >= 1) begin
        checks++; if (pix_out_valid !== 1'b1 || pix_color !== lit[k-1] || pix_color !== exp_c) $display("[TB] FAIL co_color%0d: got %b/%h expected 1/%h", k - 1, pix_out_valid, pix_color, lit[k-1]); else passed++;
      end
    end
    frame_start = 0;
  endtask

  task automatic test_drop();
    write_col(700, 50, 8'hAA, 0);
    checks++; if (col_drop !== 1'b1) $display("[TB] FAIL drop_pulse: got %b expected 1", col_drop); else passed++;
    pix_valid = 1; pix_x = 10'd650; pix_y = 10'd300;
    tick();
    checks++; if (col_drop !== 1'b0) $display("[TB] FAIL drop_len: got %b expected 0", col_drop); else passed++;
    pix_x = 10'd1023;
    tick();
    pix_valid = 0;
    checks++; if (pix_out_valid !== 1'b1 || pix_color !== 8'h00) $display("[TB] FAIL oor_650: got %b/%h expected 1/00", pix_out_valid, pix_color); else passed++;
    tick();
    checks++; if (pix_out_valid !== 1'b1 || pix_color !== 8'h00) $display("[TB] FAIL oor_1023: got %b/%h expected 1/00", pix_out_valid, pix_color); else passed++;
  endtask

  task automatic test_shade();
    logic [7:0] shaded;
`ifdef COLUMN_SHADE_EN
    shaded = 8'h6D;
`else
    shaded = 8'hFF;
`endif
    for (int i = 0; i < 640; i++) write_col(i, 600, (i == 5 || i == 6) ? 8'hFF : 8'h03, i == 5);
    frame_start = 1;
    tick();
    frame_start = 0;
    pix_valid = 1; pix_x = 10'd5; pix_y = 10'd300;
    tick();
    pix_x = 10'd6;
    tick();
    pix_valid = 0;
    checks++; if (pix_out_valid !== 1'b1 || pix_color !== shaded) $display("[TB] FAIL shade_y: got %b/%h expected 1/%h", pix_out_valid, pix_color, shaded); else passed++;
    tick();
    checks++; if (pix_out_valid !== 1'b1 || pix_color !== 8'hFF) $display("[TB] FAIL shade_x: got %b/%h expected 1/ff", pix_out_valid, pix_color); else passed++;
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 4000; n++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      col_valid = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 99);
      if (r < 3) col_index = 10'($urandom_range(640, 1023));
      else if (r < 8) col_index = 10'd639;
      else col_index = 10'($urandom_range(0, 639));
      r = $urandom_range(0, 9);
      col_height = (r == 0) ? 10'd0 : (r == 1) ? 10'd600 : 10'($urandom_range(0, 1023));
      col_color = 8'($urandom);
      col_y_side = 1'($urandom);
      frame_start = ($urandom_range(0, 29) == 0);
      if (frame_start && m_complete && col_valid && col_index == 10'd639) col_index = 10'd638;
      pix_valid = ($urandom_range(0, 9) < 7);
      pix_x = 10'($urandom_range(0, 700));
      pix_y = 10'($urandom_range(0, 650));
      tick();
      checks++; if (pix_out_valid !== exp_v) $display("[TB] FAIL rnd_valid@%0d: got %b expected %b", n, pix_out_valid, exp_v); else passed++;
      if (exp_v && exp_k) begin
        checks++; if (pix_color !== exp_c) $display("[TB] FAIL rnd_color@%0d: got %h expected %h", n, pix_color, exp_c); else passed++;
      end
      checks++; if (frame_swapped !== exp_sw) $display("[TB] FAIL rnd_swap@%0d: got %b expected %b", n, frame_swapped, exp_sw); else passed++;
      checks++; if (col_drop !== exp_dr) $display("[TB] FAIL rnd_drop@%0d: got %b expected %b", n, col_drop, exp_dr); else passed++;
    end
    rst_n = 1; col_valid = 0; frame_start = 0; pix_valid = 0;
  endtask

  initial begin
    rst_n = 0; col_valid = 0; col_index = 0; col_height = 0; col_color = 0; col_y_side = 0;
    frame_start = 0; pix_valid = 0; pix_x = 0; pix_y = 0;
    test_reset();
    test_full_frame();
    test_edge_heights();
    test_coincident();
    test_drop();
    test_shade();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/column_frame_buffer.md
# column_frame_buffer

Receiving end of the ray-cast column stream. Accepts column packets (`col_valid`, `col_index`, `col_height`, `col_color`, `col_y_side`) into a double-buffered column RAM. Back bank swaps to front at `frame_start` once a full frame has arrived. Serves per-pixel colour lookups from the VGA timing path with a fixed 2-cycle latency.

## Interface
- `SCREEN_WIDTH`, 640, columns per frame; valid `col_index` range 0..SCREEN_WIDTH-1
- `SCREEN_HEIGHT`, 600, visible rows; wall heights clamp to this
- `CEIL_COLOR`, 8'h25, RGB332 colour above the wall slice
- `FLOOR_COLOR`, 8'h49, RGB332 colour below the wall slice
- `clk`  in  1  single system clock; all logic on posedge
- `rst_n`  in  1  synchronous, active-low reset
- `col_valid`  in  1  column packet strobe, one packet per asserted cycle, no backpressure
- `col_index`  in  10  target column
- `col_height`  in  10  wall slice height in pixels
- `col_color`  in  8  RGB332 wall colour
- `col_y_side`  in  1  wall hit on a y-side (shade request)
- `frame_start`  in  1  one-cycle pulse at VGA vsync; swap point
- `pix_valid`  in  1  pixel lookup request
- `pix_x`  in  10  pixel column
- `pix_y`  in  10  pixel row
- `pix_out_valid`  out  1  `pix_valid` delayed exactly 2 cycles
- `pix_color`  out  8  RGB332 pixel colour, qualified by `pix_out_valid`
- `frame_swapped`  out  1  one-cycle pulse, the cycle after a swap is taken
- `col_drop`  out  1  one-cycle pulse, the cycle after an out-of-range packet

## Operation
- **Storage:** two banks of SCREEN_WIDTH entries, each entry {height, colour, y_side}. `front_sel` names the displayed bank; writes always target the other (back) bank.
- **Write:** on `col_valid` with `col_index < SCREEN_WIDTH`, write to back[`col_index`].
  - Stored height = min(`col_height`, SCREEN_HEIGHT).
  - With `col_index >= SCREEN_WIDTH`: no write; `col_drop` pulses next cycle.
- **Completion:** `complete` sets when index SCREEN_WIDTH-1 is written. It clears when a swap is taken. No per-column bitmap is kept.
- **Swap:** on `frame_start`, uses the registered value of `complete` from before this cycle.
  - If `complete` = 1: toggle `front_sel`, clear `complete`, set `have_frame`, pulse `frame_swapped` next cycle.
  - If `complete` = 0: no swap; the front bank keeps displaying.
- **Simultaneous events:**
  - Write of index SCREEN_WIDTH-1 in the same cycle as `frame_start`: the write lands in the current back bank, no swap occurs, and `complete` = 1 afterwards. The swap happens at the next `frame_start`.
  - A write in the same cycle as a swap targets the pre-swap back bank.
- **Pixel lookup:**
  - Stage 1 reads front[`pix_x`] using the `front_sel` in effect that cycle, and registers `pix_y` and the range flag.
  - Stage 2 computes top = (SCREEN_HEIGHT − h) >> 1 and bottom = top + h, using 11-bit unsigned arithmetic with no wrap.
  - Colour selection in stage 2:
    - `pix_y` < top: CEIL_COLOR.
    - `pix_y` >= bottom: FLOOR_COLOR.
    - Otherwise: wall colour, shaded per Configuration.
- **Defined-output overrides:**
  - `pix_x >= SCREEN_WIDTH`: colour 8'h00, valid still asserted.
  - `have_frame` = 0: colour 8'h00.
- **Boundaries:**
  - h = 0: top = bottom = SCREEN_HEIGHT/2, so no wall pixels.
  - h = SCREEN_HEIGHT: top = 0, whole column is wall.
  - Odd h: top rounds down.
- **Reset:** `front_sel` = 0, `complete` = 0, `have_frame` = 0, pipeline valids = 0. All outputs = 0. RAM contents are not cleared.
- **Reset mid-frame:** partial back-bank data is discarded logically (`complete` = 0). Lookups return 8'h00 until the first swap after reset.

## Timing
- Write to RAM: 1 cycle. A packet written in cycle N is readable from the back bank from N+1; it is visible on `pix_color` only after a swap.
- Lookup latency: 2 cycles. `pix_valid` at N gives `pix_out_valid`/`pix_color` at N+2. Fully pipelined, one lookup per cycle.
- `frame_swapped` / `col_drop`: asserted exactly one cycle, at N+1 after the causing input at N.
- A swap at cycle N affects lookups issued at N+1 and later. Lookups already in flight complete from the old bank.
- All outputs are registered; nothing is combinational from inputs.

## Configuration
- `COLUMN_SHADE_EN` defined:
  - `y_side` is stored (entry width 19 bits).
  - Wall pixels with `y_side` = 1 output halved RGB332: {1'b0,c[7:6],1'b0,c[4:3],1'b0,c[1]}.
- Undefined:
  - `y_side` is ignored and not stored (entry width 18 bits).
  - Wall pixels always output `col_color` unmodified.
- No other behaviour changes.

## Test plan
- Reset, then lookup (x=5, y=300) with no frame → `pix_out_valid` at +2 cycles, `pix_color` = 8'h00, `frame_swapped` stays 0.
- Write all 640 columns with height 200, colour 8'hE0, then `frame_start` → `frame_swapped` pulse next cycle. Lookups at column 10: y=199 → 8'h25; y=200 → 8'hE0; y=399 → 8'hE0; y=400 → 8'h49.
- Edge heights: column 0 with h=0, column 1 with h=1023 (clamped to 600), then swap → column 0 at y=299 → 8'h25 and y=300 → 8'h49; column 1 at y=0 and y=599 → wall colour.
- Write of index 639 coincident with `frame_start` → no `frame_swapped`. Next `frame_start` → swap occurs. Back-to-back lookups show the old colour before the swap and the new colour for lookups issued the cycle after.
- `col_index` = 700 → `col_drop` pulse, no RAM change. Lookup with `pix_x` = 650 → 8'h00 with `pix_out_valid` = 1.
- Wall colour 8'hFF with `y_side` = 1 → 8'h6D with `COLUMN_SHADE_EN` defined; 8'hFF without it.
